// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MEM-stage store path: store op encodings,
// store FSM states, byte-lane geometry and the formatted-request struct.
package mips_mem_pkg;

    // Byte lanes on the 32-bit data-memory port
    localparam int BE_W      = 4;
    localparam int NUM_LANES = BE_W;
    localparam int LANE_W    = 8;
    localparam int DATA_W    = NUM_LANES * LANE_W;

    typedef enum logic [1:0] {
        OP_SB  = 2'b00,
        OP_SH  = 2'b01,
        OP_SW  = 2'b10,
        OP_RSV = 2'b11
    } st_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } st_state_e;

    // Lane-formatted store as it is presented to memory
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [BE_W-1:0]   be;
    } st_fmt_t;

endpackage

// File: rtl/store_lane_pack.sv
// Combinational store formatter: replicates the narrow store value onto
// every byte lane, selects byte enables from the low address bits and
// flags misaligned or reserved-op requests.
module store_lane_pack
    import mips_mem_pkg::*;
(
    input  logic [1:0]        op,
    input  logic [1:0]        addr_lo,
    input  logic [DATA_W-1:0] wdata,
    output st_fmt_t           fmt,
    output logic              misalign
);

    logic [NUM_LANES-1:0][LANE_W-1:0] lane_d;
    logic [NUM_LANES-1:0]             lane_be;

    // Per-lane data and enable: SB replicates byte 0, SH replicates the
    // low half (lane i takes byte i%2), SW passes lanes straight through.
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        localparam logic [1:0] LANE = 2'(i);

        assign lane_d[i] = (op == OP_SB) ? wdata[LANE_W-1:0] :
                           (op == OP_SH) ? wdata[(i % 2)*LANE_W +: LANE_W] :
                                           wdata[i*LANE_W +: LANE_W];

        assign lane_be[i] = (op == OP_SB) ? (addr_lo == LANE) :
                            (op == OP_SH) ? (addr_lo[1] == LANE[1]) :
                            (op == OP_SW);
    end

    assign fmt.data = lane_d;
    assign fmt.be   = lane_be;

    // SB never faults; SH needs an even address, SW a word address
    assign misalign = (op == OP_RSV)
                    | ((op == OP_SH) & addr_lo[0])
                    | ((op == OP_SW) & (|addr_lo));

endmodule

// File: rtl/store_lane_pack_unit.sv
// MEM-stage store unit: formats SB/SH/SW stores onto byte lanes and
// drives a single outstanding write to data memory with req/ack.
// Optional feature: define STORE_TIMEOUT_EN to abandon a request that is
// not acknowledged within TIMEOUT_CYC cycles and pulse 'timeout'.
module store_lane_pack_unit
    import mips_mem_pkg::*;
#(
    parameter int AW          = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_op,
    input  logic [AW-1:0]     in_addr,
    input  logic [DATA_W-1:0] in_wdata,
    output logic              mem_req,
    output logic [AW-1:0]     mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [BE_W-1:0]   mem_be,
    input  logic              mem_ack,
    output logic              done,
    output logic              misalign,
    output logic              timeout
);

    st_state_e state, state_nxt;
    st_fmt_t   fmt;
    logic      bad;
    logic      accept;
    logic      reject;
    logic      tmo_hit;

    store_lane_pack u_pack (
        .op       (in_op),
        .addr_lo  (in_addr[1:0]),
        .wdata    (in_wdata),
        .fmt      (fmt),
        .misalign (bad)
    );

    assign accept = (state == ST_IDLE) & in_valid & ~bad;
    assign reject = (state == ST_IDLE) & in_valid & bad;

`ifdef STORE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] wait_cnt;

    // Count unacknowledged REQ cycles; parked at zero while idle so every
    // new request starts from a clean count.
    always_ff @(posedge clk) begin
        if (rst)
            wait_cnt <= '0;
        else if (state == ST_IDLE)
            wait_cnt <= '0;
        else if (!mem_ack)
            wait_cnt <= wait_cnt + 1'b1;
    end

    // Limit reached on this edge; an ack on the same edge takes priority
    assign tmo_hit = (state == ST_REQ) & ~mem_ack
                   & (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));

    // Timeout pulse, one cycle after the abandoning edge
    always_ff @(posedge clk) begin
        if (rst)
            timeout <= 1'b0;
        else
            timeout <= tmo_hit;
    end
`else
    assign tmo_hit = 1'b0;
    assign timeout = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state: accept a legal store, leave REQ on ack (or timeout)
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (accept)             state_nxt = ST_REQ;
            ST_REQ:  if (mem_ack || tmo_hit) state_nxt = ST_IDLE;
            default:                         state_nxt = ST_IDLE;
        endcase
    end

    // Handshake outputs follow the state directly
    always_comb begin
        in_ready = (state == ST_IDLE);
        mem_req  = (state == ST_REQ);
    end

    // Capture the formatted request on accept; held stable through REQ
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
        end else if (accept) begin
            mem_addr  <= {in_addr[AW-1:2], 2'b00};
            mem_wdata <= fmt.data;
            mem_be    <= fmt.be;
        end
    end

    // Completion and rejection pulses, one cycle after the deciding edge
    always_ff @(posedge clk) begin
        if (rst) begin
            done     <= 1'b0;
            misalign <= 1'b0;
        end else begin
            done     <= (state == ST_REQ) & mem_ack;
            misalign <= reject;
        end
    end

endmodule

// File: doc/store_lane_pack_unit.md
# store_lane_pack_unit

MEM-stage store path of the pipelined MIPS core: the write-side counterpart of the load sign-extension path. Takes a store request (SB/SH/SW) with the full 32-bit register value, narrows and replicates it onto the correct byte lanes, generates byte enables, checks alignment, and drives a single outstanding request to data memory with a req/ack handshake. Sits between the EX/MEM pipeline register and the data-memory port.

## Interface
Parameters:
- AW, 32, byte-address width.
- TIMEOUT_CYC, 16, ack-wait limit in cycles (used only with the timeout feature).

Ports:
- clk  in  1  rising-edge clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  store request present.
- in_ready  out  1  unit can accept; high only in IDLE.
- in_op  in  2  00=SB, 01=SH, 10=SW, 11=reserved.
- in_addr  in  AW  byte address.
- in_wdata  in  32  source register value; low byte/half used for SB/SH.
- mem_req  out  1  memory request valid.
- mem_addr  out  AW  word-aligned address, addr[1:0] forced to 00.
- mem_wdata  out  32  lane-formatted store data.
- mem_be  out  4  byte enables, bit i = byte lane i (little-endian).
- mem_ack  in  1  memory accepted write.
- done  out  1  one-cycle pulse, store completed.
- misalign  out  1  one-cycle pulse, request rejected.
- timeout  out  1  one-cycle pulse, ack never arrived (feature-gated; tied 0 otherwise).

## Operation
- States: IDLE, REQ. Reset -> IDLE.
- IDLE: in_ready=1. On in_valid: if aligned and op valid -> capture formatted request, go REQ; else pulse misalign next cycle, stay IDLE, no memory request.
- Alignment: SB always legal; SH requires addr[0]=0; SW requires addr[1:0]=00; op 11 always misaligned.
- Formatting: SB -> mem_wdata = 4 copies of wdata[7:0], mem_be = 0001 << addr[1:0]. SH -> 2 copies of wdata[15:0], mem_be = 0011 when addr[1]=0, 1100 when addr[1]=1. SW -> wdata unchanged, mem_be = 1111.
- REQ: mem_req=1, mem_addr/mem_wdata/mem_be held stable until ack. On mem_ack -> IDLE, pulse done.
- mem_ack while mem_req=0 ignored. in_valid while in REQ ignored (in_ready=0).

## Timing
- Reset values: in_ready=1 after reset edge; mem_req, mem_be, done, misalign, timeout = 0; mem_addr, mem_wdata = 0.
- Accept at edge N -> mem_req high in cycle N+1.
- mem_ack sampled high at edge M -> mem_req low and done high in cycle M+1; in_ready high in M+1, new request may be accepted at edge M+1 (back-to-back throughput: one store per 2 cycles with zero-wait ack).
- Misalign: rejected at edge N -> misalign high cycle N+1 only.
- rst asserted mid-REQ: request dropped at that edge, no done pulse, captured data cleared.

## Configuration
- STORE_TIMEOUT_EN defined: counter cleared on entry to REQ, increments each REQ cycle without ack; when it reaches TIMEOUT_CYC, drop mem_req, go IDLE, pulse timeout, no done. Ack on the same edge as the limit wins (done, not timeout).
- Undefined: no counter; REQ waits indefinitely; timeout tied 0.

## Structure
- Shared package mips_mem_pkg: store op encodings (SB/SH/SW), state enum (IDLE/REQ), byte-enable width constant 4.
- One combinational sub-module store_lane_pack: op, addr[1:0], wdata -> formatted data, byte enables, misalign flag. FSM, capture registers, and timeout counter in the top.

## Test plan
- SB addr=0x1003 wdata=0xDEADBEEF, ack after 2 cycles -> mem_addr=0x1000, mem_wdata=0xEFEFEFEF, mem_be=1000, done one cycle after ack.
- SH addr=0x2002 wdata=0x1234ABCD, zero-wait ack -> mem_wdata=0xABCDABCD, mem_be=1100; second SW accepted in done cycle, mem_be=1111.
- SH addr=0x2001, then SW addr=0x3002, then op=11 -> three misalign pulses, mem_req never asserts.
- in_valid held during REQ with different data -> mem outputs unchanged until ack; second request captured only after return to IDLE.
- rst asserted in second REQ cycle -> mem_req low next cycle, no done, in_ready=1.
- With STORE_TIMEOUT_EN, TIMEOUT_CYC=4, ack never given -> mem_req drops after 4 REQ cycles, timeout pulses once; ack on the 4th edge -> done instead.
